// File: rtl/dcache_mem_responder.sv
// D-cache block responder: evictions are written back and miss fills are read, one
// beat at a time over a single-outstanding memory port. The optional stats outputs
// fillCount/evictCount are built only when DCACHE_MEM_STATS_EN is defined.
module dcache_mem_responder #(
    parameter int ADDR_W = 32,
    parameter int BLK_W  = 512,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cacheMiss,
    input  logic [ADDR_W-1:0] missAddr,
    input  logic              cacheEvict,
    input  logic [ADDR_W-1:0] evictAddr,
    input  logic [BLK_W-1:0]  evictData,
    output logic [BLK_W-1:0]  fillData,
    output logic              fillValid,
    output logic              evictDone,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [BEAT_W-1:0] memWData,
    input  logic              memGnt,
    input  logic              memRValid,
    input  logic [BEAT_W-1:0] memRData,
    output logic              busy
`ifdef DCACHE_MEM_STATS_EN
    ,
    output logic [15:0]       fillCount,
    output logic [15:0]       evictCount
`endif
);

    localparam int NBEATS     = BLK_W / BEAT_W;
    localparam int BEAT_CW    = $clog2(NBEATS);
    localparam int BYTE_OFF_W = $clog2(BEAT_W / 8);
    localparam int BLK_OFF_W  = BEAT_CW + BYTE_OFF_W;
    localparam int BLKA_W     = ADDR_W - BLK_OFF_W;

    localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(NBEATS - 1);
    localparam logic [BEAT_CW-1:0] BEAT_ONE  = BEAT_CW'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WB        = 3'd1;
    localparam logic [2:0] S_WB_DONE   = 3'd2;
    localparam logic [2:0] S_FILL_REQ  = 3'd3;
    localparam logic [2:0] S_FILL_WAIT = 3'd4;
    localparam logic [2:0] S_FILL_DONE = 3'd5;

    logic [2:0]                    state_q, state_d;
    logic [BEAT_CW-1:0]            beat_q, beat_d;
    logic [BLKA_W-1:0]             blk_addr_q, blk_addr_d;
    logic [NBEATS-1:0][BEAT_W-1:0] evict_beats_q, evict_beats_d;
    logic [NBEATS-1:0][BEAT_W-1:0] fill_beats_q, fill_beats_d;
    logic                          beat_last;

    // The byte offset within a block never reaches the memory port.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{missAddr[BLK_OFF_W-1:0], evictAddr[BLK_OFF_W-1:0]};

    assign beat_last = (beat_q == LAST_BEAT);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path through
        // the case statement leaves one unassigned, which would infer a latch.
        state_d       = state_q;
        beat_d        = beat_q;
        blk_addr_d    = blk_addr_q;
        evict_beats_d = evict_beats_q;
        fill_beats_d  = fill_beats_q;

        case (state_q)
            S_IDLE: begin
                if (cacheEvict) begin
                    blk_addr_d    = evictAddr[ADDR_W-1:BLK_OFF_W];
                    evict_beats_d = evictData;
                    beat_d        = '0;
                    state_d       = S_WB;
                end else if (cacheMiss) begin
                    blk_addr_d = missAddr[ADDR_W-1:BLK_OFF_W];
                    beat_d     = '0;
                    state_d    = S_FILL_REQ;
                end
            end
            S_WB: begin
                if (memGnt) begin
                    beat_d = beat_q + BEAT_ONE;
                    if (beat_last) begin
                        state_d = S_WB_DONE;
                    end
                end
            end
            S_WB_DONE: begin
                state_d = S_IDLE;
            end
            S_FILL_REQ: begin
                if (memGnt) begin
                    state_d = S_FILL_WAIT;
                end
            end
            S_FILL_WAIT: begin
                if (memRValid) begin
                    fill_beats_d[beat_q] = memRData;
                    beat_d               = beat_q + BEAT_ONE;
                    state_d              = beat_last ? S_FILL_DONE : S_FILL_REQ;
                end
            end
            S_FILL_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the block-wide data latches are reset as well, because an aborted
            // fill must leave fillData at 0 rather than partially overwritten.
            state_q       <= S_IDLE;
            beat_q        <= '0;
            blk_addr_q    <= '0;
            evict_beats_q <= '0;
            fill_beats_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q       <= state_d;
            beat_q        <= beat_d;
            blk_addr_q    <= blk_addr_d;
            evict_beats_q <= evict_beats_d;
            fill_beats_q  <= fill_beats_d;
        end
    end

    assign memReq    = (state_q == S_WB) || (state_q == S_FILL_REQ);
    assign memWe     = (state_q == S_WB);
    assign memAddr   = memReq ? {blk_addr_q, beat_q, {BYTE_OFF_W{1'b0}}} : '0;
    assign memWData  = (state_q == S_WB) ? evict_beats_q[beat_q] : '0;
    assign evictDone = (state_q == S_WB_DONE);
    assign fillValid = (state_q == S_FILL_DONE);
    assign busy      = (state_q != S_IDLE);
    assign fillData  = fill_beats_q;

`ifdef DCACHE_MEM_STATS_EN
    logic [15:0] fill_count_q;
    logic [15:0] evict_count_q;

    // Saturating completion counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_count_q  <= '0;
            evict_count_q <= '0;
        end else begin
            if (state_q == S_FILL_DONE && fill_count_q != 16'hFFFF) begin
                fill_count_q <= fill_count_q + 16'd1;
            end
            if (state_q == S_WB_DONE && evict_count_q != 16'hFFFF) begin
                evict_count_q <= evict_count_q + 16'd1;
            end
        end
    end

    assign fillCount  = fill_count_q;
    assign evictCount = evict_count_q;
`endif

    a_pulses_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(evictDone && fillValid));
    a_idle_bus_zero: assert property (@(posedge clk) disable iff (!rst_n)
        !memReq |-> (memAddr == '0 && memWData == '0));
    a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (memReq && !memGnt) |=> (memReq && $stable(memAddr)));
    a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
        state_q <= S_FILL_DONE);

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Bench for dcache_mem_responder: directed vector table, reset-abort sequence and
// randomized transactions against a transaction-level memory and block model.
module tb_dcache_mem_responder;

    localparam int ADDR_W = 32;
    localparam int BLK_W  = 512;
    localparam int BEAT_W = 64;
    localparam int NV     = 7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cacheMiss;
    logic [ADDR_W-1:0] missAddr;
    logic              cacheEvict;
    logic [ADDR_W-1:0] evictAddr;
    logic [BLK_W-1:0]  evictData;
    logic [BLK_W-1:0]  fillData;
    logic              fillValid;
    logic              evictDone;
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [BEAT_W-1:0] memWData;
    logic              memGnt;
    logic              memRValid;
    logic [BEAT_W-1:0] memRData;
    logic              busy;
`ifdef DCACHE_MEM_STATS_EN
    logic [15:0]       fillCount;
    logic [15:0]       evictCount;
`endif

    dcache_mem_responder #(.ADDR_W(ADDR_W), .BLK_W(BLK_W), .BEAT_W(BEAT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cacheMiss  (cacheMiss),
        .missAddr   (missAddr),
        .cacheEvict (cacheEvict),
        .evictAddr  (evictAddr),
        .evictData  (evictData),
        .fillData   (fillData),
        .fillValid  (fillValid),
        .evictDone  (evictDone),
        .memReq     (memReq),
        .memWe      (memWe),
        .memAddr    (memAddr),
        .memWData   (memWData),
        .memGnt     (memGnt),
        .memRValid  (memRValid),
        .memRData   (memRData),
        .busy       (busy)
`ifdef DCACHE_MEM_STATS_EN
        ,
        .fillCount  (fillCount),
        .evictCount (evictCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ev;
        bit          ms;
        logic [31:0] ea;
        logic [31:0] ma;
        logic [511:0] ed;
        logic [63:0] salt;
        int          stall_beat;
        int          stall_n;
        int          rdly_beat;
        int          rdly_n;
        int          exp_ev;
        int          exp_fl;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Memory model controls and observation logs
    logic [63:0] cur_salt;
    bit          rand_mem;
    int          stall_beat, stall_left, rdly_beat, rdly_n;
    logic [31:0] wr_addr_log[$];
    logic [63:0] wr_data_log[$];
    logic [31:0] rd_addr_log[$];
    int          stable_err, zero_err;
    bit          acc_seen;
    logic [31:0] acc_addr;
    bit          acc_we;
    logic [63:0] acc_wdata;
    bit          prev_wait;
    logic [31:0] prev_addr;
    bit          prev_we;
    logic [63:0] prev_wdata;
    bit          rd_pending;
    int          rd_cnt;
    logic [31:0] rd_addr;
    logic [511:0] last_fill_exp;
    int          exp_fills, exp_evicts;

    task automatic check(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Backing-memory contents: the beat index lives in the low bits, the salt elsewhere.
    function automatic logic [63:0] mem_data(input logic [31:0] a);
        return {32'h1111_1111 ^ cur_salt[63:32], cur_salt[31:3], a[5:3]};
    endfunction

    function automatic logic [511:0] exp_fill(input logic [31:0] base);
        logic [511:0] r;
        for (int i = 0; i < 8; i++) r[i*64 +: 64] = mem_data(base + 32'(8 * i));
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Mid-cycle monitor: records handshakes and checks bus holding / idle-zero rules.
    initial begin
        prev_wait = 0;
        acc_seen  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_wait = 0;
                acc_seen  = 0;
            end else begin
                if (prev_wait && (memReq !== 1'b1 || memAddr !== prev_addr ||
                                  memWe !== prev_we || memWData !== prev_wdata))
                    stable_err++;
                if (memReq !== 1'b1 && (memAddr !== '0 || memWData !== '0))
                    zero_err++;
                acc_seen   = (memReq === 1'b1) && (memGnt === 1'b1);
                acc_addr   = memAddr;
                acc_we     = memWe;
                acc_wdata  = memWData;
                prev_wait  = (memReq === 1'b1) && (memGnt !== 1'b1);
                prev_addr  = memAddr;
                prev_we    = memWe;
                prev_wdata = memWData;
            end
        end
    end

    // Memory responder: drives grant and read data just after each rising edge.
    initial begin
        memGnt     = 0;
        memRValid  = 0;
        memRData   = '0;
        rd_pending = 0;
        rd_cnt     = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                rd_pending = 0;
                acc_seen   = 0;
                memGnt     = 0;
                memRValid  = 0;
                memRData   = '0;
            end else begin
                if (acc_seen) begin
                    acc_seen = 0;
                    if (acc_we) begin
                        wr_addr_log.push_back(acc_addr);
                        wr_data_log.push_back(acc_wdata);
                    end else begin
                        rd_addr_log.push_back(acc_addr);
                        rd_pending = 1;
                        rd_addr    = acc_addr;
                        if (rand_mem) rd_cnt = $urandom_range(0, 3);
                        else rd_cnt = (int'(acc_addr[5:3]) == rdly_beat) ? rdly_n : 0;
                    end
                end
                memRValid = 0;
                memRData  = rand_mem ? {$urandom, $urandom} : 64'h0;
                if (rd_pending) begin
                    if (rd_cnt == 0) begin
                        memRValid  = 1;
                        memRData   = mem_data(rd_addr);
                        rd_pending = 0;
                    end else begin
                        rd_cnt--;
                    end
                end else if (rand_mem && $urandom_range(0, 3) == 0) begin
                    memRValid = 1;  // stray data outside a read window
                end
                if (memReq === 1'b1) begin
                    if (stall_left > 0 && int'(memAddr[5:3]) == stall_beat) begin
                        memGnt = 0;
                        stall_left--;
                    end else if (rand_mem) begin
                        memGnt = ($urandom_range(0, 3) != 0);
                    end else begin
                        memGnt = 1;
                    end
                end else begin
                    memGnt = rand_mem ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one request (or an evict+miss pair) like a cache would: levels held until done.
    task automatic run_txn(input bit ev, input bit ms, input logic [31:0] ea, input logic [31:0] ma,
                           input logic [511:0] ed, input bit scramble,
                           output int ev_cyc, output int fl_cyc, output int n_ev, output int n_fl);
        int tail;
        wr_addr_log.delete();
        wr_data_log.delete();
        rd_addr_log.delete();
        stable_err = 0;
        zero_err   = 0;
        cacheEvict = ev;
        cacheMiss  = ms;
        evictAddr  = ea;
        missAddr   = ma;
        evictData  = ed;
        ev_cyc = -1;
        fl_cyc = -1;
        n_ev   = 0;
        n_fl   = 0;
        tail   = 0;
        for (int c = 1; c <= 600; c++) begin
            step();
            if (evictDone === 1'b1) begin
                n_ev++;
                if (ev_cyc < 0) ev_cyc = c;
                cacheEvict = 0;
            end
            if (fillValid === 1'b1) begin
                n_fl++;
                if (fl_cyc < 0) fl_cyc = c;
                cacheMiss = 0;
            end
            if (scramble) begin
                evictAddr = $urandom;
                evictData = rand512();
                if (rd_addr_log.size() > 0) missAddr = $urandom;
            end
            if (!cacheEvict && !cacheMiss) begin
                tail++;
                if (tail > 3) break;
            end
        end
        cacheEvict = 0;
        cacheMiss  = 0;
    endtask

    task automatic verify(input string tag, input bit ev, input bit ms, input logic [31:0] ea,
                          input logic [31:0] ma, input logic [511:0] ed, input int n_ev, input int n_fl);
        logic [31:0] eb, mb;
        int nw, nr;
        eb = {ea[31:6], 6'b0};
        mb = {ma[31:6], 6'b0};
        check({tag, "_evict_pulses"}, n_ev, ev);
        check({tag, "_fill_pulses"}, n_fl, ms);
        nw = wr_addr_log.size();
        nr = rd_addr_log.size();
        check({tag, "_write_beats"}, nw, ev ? 8 : 0);
        check({tag, "_read_beats"}, nr, ms ? 8 : 0);
        for (int i = 0; i < nw && i < 8; i++) begin
            check($sformatf("%s_wr_addr%0d", tag, i), wr_addr_log[i], eb + 32'(8 * i));
            check($sformatf("%s_wr_data%0d", tag, i), wr_data_log[i], ed[i*64 +: 64]);
        end
        for (int i = 0; i < nr && i < 8; i++)
            check($sformatf("%s_rd_addr%0d", tag, i), rd_addr_log[i], mb + 32'(8 * i));
        if (ms) last_fill_exp = exp_fill(mb);
        check({tag, "_fill_data"}, fillData, last_fill_exp);
        check({tag, "_bus_held"}, stable_err, 0);
        check({tag, "_bus_idle_zero"}, zero_err, 0);
        check({tag, "_idle_after"}, {busy, memReq, evictDone, fillValid}, 4'b0);
    endtask

    vec_t        vecs[NV];
    logic [511:0] a_pat;
    logic [511:0] part_exp;
    int          ev_cyc, fl_cyc, n_ev, n_fl, pulses;
    bit          rev, rms;
    logic [31:0] rea, rma;
    logic [511:0] red;

    initial begin
        for (int i = 0; i < 8; i++) a_pat[i*64 +: 64] = 64'hA0 + 64'(i);
        vecs[0] = '{0, 1, 32'h0, 32'h0000_1234, '0, 64'h0, -1, 0, -1, 0, -1, 17};
        vecs[1] = '{1, 0, 32'h0000_4040, 32'h0, a_pat, 64'h0, -1, 0, -1, 0, 9, -1};
        vecs[2] = '{1, 1, 32'h0000_8000, 32'h0000_1234, rand512(), 64'hDEAD_BEEF_CAFE_F00D, -1, 0, -1, 0, 9, 27};
        vecs[3] = '{0, 1, 32'h0, 32'hFFFF_FFFF, '0, 64'h5A5A_0F0F_1234_8888, -1, 0, -1, 0, -1, 17};
        vecs[4] = '{1, 0, 32'h0000_003F, 32'h0, rand512(), 64'h0, -1, 0, -1, 0, 9, -1};
        vecs[5] = '{0, 1, 32'h0, 32'h0000_2000, '0, 64'h0BAD_F00D_0000_1110, 2, 3, 5, 4, -1, 24};
        vecs[6] = '{1, 0, 32'h1000_0080, 32'h0, rand512(), 64'h0, 2, 3, -1, 0, 12, -1};

        rst_n      = 0;
        cacheMiss  = 0;
        cacheEvict = 0;
        missAddr   = '0;
        evictAddr  = '0;
        evictData  = '0;
        cur_salt   = '0;
        rand_mem   = 0;
        stall_beat = -1;
        stall_left = 0;
        rdly_beat  = -1;
        rdly_n     = 0;
        last_fill_exp = '0;
        exp_fills  = 0;
        exp_evicts = 0;

        #2;
        check("reset_fillData", fillData, '0);
        check("reset_ctrl", {memReq, memWe, fillValid, evictDone, busy}, 5'b0);
        check("reset_bus", {memAddr, memWData}, '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        step();

        for (int v = 0; v < NV; v++) begin
            cur_salt   = vecs[v].salt;
            stall_beat = vecs[v].stall_beat;
            stall_left = vecs[v].stall_n;
            rdly_beat  = vecs[v].rdly_beat;
            rdly_n     = vecs[v].rdly_n;
            run_txn(vecs[v].ev, vecs[v].ms, vecs[v].ea, vecs[v].ma, vecs[v].ed, 1'b0,
                    ev_cyc, fl_cyc, n_ev, n_fl);
            check($sformatf("v%0d_evict_cycle", v), ev_cyc, vecs[v].exp_ev);
            check($sformatf("v%0d_fill_cycle", v), fl_cyc, vecs[v].exp_fl);
            verify($sformatf("v%0d", v), vecs[v].ev, vecs[v].ms, vecs[v].ea, vecs[v].ma,
                   vecs[v].ed, n_ev, n_fl);
            exp_evicts += vecs[v].ev ? 1 : 0;
            exp_fills  += vecs[v].ms ? 1 : 0;
        end
        stall_left = 0;
        rdly_n     = 0;

        // Reset in the middle of a fill, right after beat 3 is captured.
        cur_salt  = 64'h0123_4567_89AB_CDEF;
        missAddr  = 32'h0000_7777;
        cacheMiss = 1;
        repeat (9) step();
        part_exp = exp_fill(32'h0000_7740);
        check("rst_partial_fill", fillData[255:0], part_exp[255:0]);
        check("rst_busy_before", busy, 1'b1);
        #1 rst_n = 0;
        cacheMiss = 0;
        #1;
        check("rst_fillData_cleared", fillData, '0);
        check("rst_ctrl_cleared", {memReq, memWe, busy, fillValid, evictDone}, 5'b0);
        check("rst_bus_cleared", {memAddr, memWData}, '0);
        pulses = 0;
        repeat (3) begin
            step();
            if (fillValid !== 1'b0) pulses++;
        end
        check("rst_no_fill_pulse", pulses, 0);
        rst_n = 1;
        last_fill_exp = '0;
        exp_fills  = 0;
        exp_evicts = 0;
        step();
        cur_salt = 64'h7777_0000_AAAA_5550;
        run_txn(1'b0, 1'b1, 32'h0, 32'h0000_3010, '0, 1'b0, ev_cyc, fl_cyc, n_ev, n_fl);
        check("post_rst_fill_cycle", fl_cyc, 17);
        verify("post_rst", 1'b0, 1'b1, 32'h0, 32'h0000_3010, '0, n_ev, n_fl);
        exp_fills++;

        // Randomized traffic with random grant/read stalls and stray read data.
        rand_mem = 1;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0: begin rev = 1; rms = 0; end
                1: begin rev = 0; rms = 1; end
                default: begin rev = 1; rms = 1; end
            endcase
            rea      = $urandom;
            rma      = $urandom;
            red      = rand512();
            cur_salt = {$urandom, $urandom};
            run_txn(rev, rms, rea, rma, red, 1'b1, ev_cyc, fl_cyc, n_ev, n_fl);
            verify($sformatf("r%0d", t), rev, rms, rea, rma, red, n_ev, n_fl);
            exp_evicts += rev ? 1 : 0;
            exp_fills  += rms ? 1 : 0;
        end
        rand_mem = 0;

`ifdef DCACHE_MEM_STATS_EN
        check("stats_fill_count", fillCount, 16'(exp_fills));
        check("stats_evict_count", evictCount, 16'(exp_evicts));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
